pipe_reg_chain: RTL
===================

Name: pipe_reg_chain

Overview:
- Parametrised successor to the team's flat 32-bit clocked register: a DEPTH-stage, WIDTH-bit pipeline register chain with a valid/ready handshake, backpressure, bubble collapsing, synchronous flush and an occupancy count.
- Used between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and as a retiming delay line wherever stall and flush support is needed.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every data stage on reset (WIDTH bits).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; invalidates all stages.
- in_valid  input  1  upstream has data on in_data.
- in_ready  output  1  chain accepts in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  stage DEPTH-1 holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  data of stage DEPTH-1.
- count  output  $clog2(DEPTH+1)  number of valid stages (0..DEPTH).
- inj_par  input  1  parity-error injection; used only with PIPE_REG_PARITY_EN.
- out_par_err  output  1  parity error on the output stage.

Behaviour:
- State: per stage i (0..DEPTH-1), v[i] (valid) and d[i] (data). Stage 0 is the input stage; stage DEPTH-1 drives out_valid/out_data.
- Reset (asynchronous, any cycle, including mid-transfer):
  - all v[i]=0 and all d[i]=RESET_VAL.
  - Outputs: out_valid=0, out_data=RESET_VAL, count=0, out_par_err=0, in_ready=1 (0 while flush=1).
- Accept chain (combinational):
  - a[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - a[i] = !v[i] | a[i+1] for i < DEPTH-1.
  - in_ready = a[0] & !flush.
- Clock edge, flush=0:
  - For each stage i with a[i]=1: v[i] <= source valid, where the source is in_valid (i=0) or v[i-1].
  - d[i] loads the source data only when the source valid is 1; otherwise d[i] keeps its value.
  - Stages with a[i]=0 hold both v and d.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Both may occur in the same cycle.
- Flush:
  - Clock edge with flush=1: all v[i] <= 0; d[i] unchanged.
  - Flush has priority over load; no input is accepted that cycle (in_ready=0).
  - Flush applied together with an output transfer: the output transfer still counts downstream, since out_valid was 1 before the edge.
- Latency and throughput:
  - With out_ready held at 1, data accepted at edge N appears on out_data with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH register stages.
  - Throughput is one word per cycle.
- Bubble collapsing: an empty stage always accepts, even while downstream is stalled, so a stalled chain fills to DEPTH words before in_ready drops.
- Full chain (all v=1) with out_ready=0: in_ready=0 and all stages hold.
- Full chain with out_ready=1: in_ready=1 combinationally and the chain shifts.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_valid stay constant.
- count: registered; equals the number of set v[i] after each edge. It is updated in the same edge as v and is never greater than DEPTH.
- Arithmetic: count is unsigned and cannot wrap.
- DEPTH=1: the chain degenerates to a single stage with in_ready = !v[0] | out_ready.

Optional Feature:
- Macro: PIPE_REG_PARITY_EN.
- Defined:
  - Each stage carries an extra parity bit p[i].
  - On an input load, p[0] <= ^in_data ^ inj_par; p moves with the data through the chain.
  - out_par_err = out_valid & (^out_data ^ p[DEPTH-1]), i.e. 1 on parity mismatch.
  - Reset clears p to ^RESET_VAL.
- Not defined: no parity storage; inj_par is ignored; out_par_err is tied 0.

Test Plan:
- Streaming: DEPTH=2, WIDTH=32, reset then release, in_valid=1 with in_data=0x1,0x2,0x3 on consecutive cycles, out_ready=1 -> out_data=0x1,0x2,0x3 on consecutive cycles starting 2 edges after the first accept; in_ready=1 throughout; count=2 at steady state.
- Backpressure fill: DEPTH=3, out_ready=0, send 0xA,0xB,0xC,0xD -> first three accepted, in_ready=0 while 0xD is offered, count=3, out_data=0xA held stable; raise out_ready -> 0xA,0xB,0xC,0xD drain in order with no loss or duplication.
- Bubble collapse: DEPTH=3, stage 2 holding 0x5 with out_ready=0, stage 1 empty, in_valid=1 with 0x6 -> 0x6 accepted and advances to stage 1; count goes 1->2.
- Flush: chain full of 0x11,0x22, flush=1 together with in_valid=1 and data 0x33 -> next cycle out_valid=0, count=0, 0x33 not accepted (in_ready=0 during flush).
- Async reset mid-operation: assert reset between clock edges while count=2 -> out_valid=0, count=0, out_data=RESET_VAL immediately without waiting for an edge; after release, the first input appears after DEPTH edges.
- Parity (PIPE_REG_PARITY_EN): send 0xFFFFFFFF with inj_par=1 -> out_par_err=1 when the word is at the output; the next word 0x1 with inj_par=0 -> out_par_err=0.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register chain with backpressure, bubble collapsing,
// synchronous flush and occupancy count. Define PIPE_REG_PARITY_EN for per-stage parity.

module pipe_reg_stage #(
  parameter int              SW       = 32,
  parameter logic [SW-1:0]   RST_WORD = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          v_nxt,
  input  logic          load,
  input  logic [SW-1:0] src,
  output logic          v,
  output logic [SW-1:0] d
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= 1'b0;
      d <= RST_WORD;
    end else begin
      v <= v_nxt;
      if (load) d <= src;
    end
  end
endmodule

module pipe_reg_chain #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       inj_par,
  output logic                       out_par_err
);
  localparam int CW = $clog2(DEPTH+1);
`ifdef PIPE_REG_PARITY_EN
  // Parity rides as the MSB of each stage word.
  localparam int            SW       = WIDTH + 1;
  localparam logic [SW-1:0] RST_WORD = {^RESET_VAL, RESET_VAL};
`else
  localparam int            SW       = WIDTH;
  localparam logic [SW-1:0] RST_WORD = RESET_VAL;
`endif

  logic [DEPTH-1:0]         v, a, src_v, v_nxt, load;
  logic [DEPTH-1:0][SW-1:0] d, src_d;
  logic [SW-1:0]            in_word;
  logic [CW-1:0]            cnt_nxt;

`ifdef PIPE_REG_PARITY_EN
  assign in_word     = {^in_data ^ inj_par, in_data};
  assign out_par_err = out_valid & (^out_data ^ d[DEPTH-1][WIDTH]);
`else
  logic unused_inj_par;
  assign unused_inj_par = inj_par;
  assign in_word        = in_data;
  assign out_par_err    = 1'b0;
`endif

  // A stage can take new data if it is empty or its successor frees it this cycle.
  always_comb begin
    a = '0;
    a[DEPTH-1] = !v[DEPTH-1] | out_ready;
    for (int i = DEPTH-2; i >= 0; i--) a[i] = !v[i] | a[i+1];
  end

  always_comb begin
    src_v    = '0;
    src_d    = '0;
    src_v[0] = in_valid;
    src_d[0] = in_word;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  always_comb begin
    v_nxt   = '0;
    load    = '0;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      load[i]  = !flush & a[i] & src_v[i];
      v_nxt[i] = flush ? 1'b0 : (a[i] ? src_v[i] : v[i]);
      cnt_nxt  = cnt_nxt + CW'(v_nxt[i]);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_reg_stage #(.SW(SW), .RST_WORD(RST_WORD)) u_stage (
      .clk   (clk),
      .reset (reset),
      .v_nxt (v_nxt[i]),
      .load  (load[i]),
      .src   (src_d[i]),
      .v     (v[i]),
      .d     (d[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else       count <= cnt_nxt;
  end

  assign in_ready  = a[0] & !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1][WIDTH-1:0];
endmodule
